// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the wide SPI sample transmitter.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    NEXT  = 2'd3
  } state_t;

  // "SLA1"
  localparam logic [31:0] SPI_TX_ID_DEFAULT = 32'h534c4131;

  // Width of the byte selector inside a sample word; never narrower than one bit.
  function automatic int byte_idx_width(input int word_bytes);
    return (word_bytes <= 2) ? 1 : $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Synchronous word FIFO for the SPI transmitter.
// Pushes while full and pops while empty are ignored; full is a registered flag.
module spi_tx_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     extReset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign count     = wr_ptr - rd_ptr;
  assign empty     = (count == '0);
  assign pop_data  = mem[rd_ptr[AW-1:0]];
  assign count_nxt = count + CW'(do_push) - CW'(do_pop);

  // Pointer and full-flag update; pointers carry one extra wrap bit.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      full <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_transmitter_wide.sv
// Buffered SPI sample transmitter: queues sample words, ID and dataIn queries,
// and shifts the valid bytes (byte 0 first, MSB first) out on tx.
// Build option: define SPI_TX_SYNC_EN to pass sclk/cs through a 2-flop
// synchroniser when the master clock is asynchronous to clock.
//
// state | meaning
// IDLE  | waiting; pops a queued word or loads a metadata byte
// LOAD  | loads the selected byte if valid, otherwise skips it
// SHIFT | shifts the loaded byte out on sclk shift edges
// NEXT  | advances to the next byte or returns to IDLE
module spi_transmitter_wide
  import spi_tx_pkg::*;
#(
  parameter int          WORD_BYTES = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter bit          CPOL       = 1'b1,
  parameter logic [31:0] ID_WORD    = SPI_TX_ID_DEFAULT
) (
  input  logic                    clock,
  input  logic                    extReset_n,
  input  logic                    sclk,
  input  logic                    cs,
  input  logic                    send,
  input  logic [WORD_BYTES*8-1:0] send_data,
  input  logic [WORD_BYTES-1:0]   send_valid,
  input  logic                    writeMeta,
  input  logic [7:0]              meta_data,
  input  logic                    query_id,
  input  logic                    query_dataIn,
  input  logic [WORD_BYTES*8-1:0] dataIn,
  output logic                    tx,
  output logic                    busy,
  output logic                    byteDone,
  output logic                    full,
  output logic                    overflow
);

  localparam int W     = WORD_BYTES * 8;
  localparam int E     = W + WORD_BYTES;
  localparam int SEL_W = byte_idx_width(WORD_BYTES);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(WORD_BYTES - 1);
  localparam logic [W-1:0]     ID_EXT = W'(ID_WORD);

  state_t                     state;
  logic [W-1:0]               word_data;
  logic [WORD_BYTES-1:0]      word_valid;
  logic [SEL_W-1:0]           bytesel;
  logic [2:0]                 bits;
  logic [2:0]                 bits_inc;
  logic [7:0]                 shift;
  logic [7:0]                 cur_byte;
  logic                       sclk_s;
  logic                       cs_s;
  logic                       dly_sclk;
  logic                       shift_edge;
  logic                       push_req;
  logic [E-1:0]               push_entry;
  logic [E-1:0]               pop_entry;
  logic                       fifo_pop;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

`ifdef SPI_TX_SYNC_EN
  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;

  // Two-flop synchronisers for an asynchronous master.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      sclk_sync <= {2{CPOL}};
      cs_sync   <= 2'b11;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs};
    end
  end

  assign sclk_s = sclk_sync[1];
  assign cs_s   = cs_sync[1];
`else
  assign sclk_s = sclk;
  assign cs_s   = cs;
`endif

  // Previous sclk sample for edge detection; resets to the idle level.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) dly_sclk <= CPOL;
    else             dly_sclk <= sclk_s;
  end

  assign shift_edge = CPOL ? (dly_sclk & ~sclk_s) : (~dly_sclk & sclk_s);
  assign bits_inc   = bits + 3'd1;
  assign cur_byte   = word_data[{bytesel, 3'b000} +: 8];
  assign push_req   = send | query_id | query_dataIn;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;

  // Push source select: send wins over query_id, which wins over query_dataIn.
  always_comb begin
    push_entry = {{WORD_BYTES{1'b1}}, dataIn};
    if (send)          push_entry = {send_valid, send_data};
    else if (query_id) push_entry = {{WORD_BYTES{1'b1}}, ID_EXT};
  end

  spi_tx_fifo #(
    .WIDTH (E),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .extReset_n (extReset_n),
    .push       (push_req),
    .push_data  (push_entry),
    .pop        (fifo_pop),
    .pop_data   (pop_entry),
    .full       (full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Transmit FSM with registered tx/busy/byteDone and sticky overflow.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state      <= IDLE;
      word_data  <= '0;
      word_valid <= '0;
      bytesel    <= '0;
      bits       <= 3'd0;
      shift      <= 8'hFF;
      tx         <= 1'b1;
      busy       <= 1'b0;
      byteDone   <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      busy <= (fifo_count != '0) || (state != IDLE) || !byteDone;
      if (push_req && full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            word_data  <= pop_entry[W-1:0];
            word_valid <= pop_entry[E-1:W];
            bytesel    <= '0;
            state      <= LOAD;
          end else if (writeMeta) begin
            shift    <= meta_data;
            bits     <= 3'd0;
            byteDone <= 1'b0;
            // A lone metadata byte must return straight to IDLE, not walk a stale word.
            bytesel  <= LAST;
            tx       <= cs_s ? 1'b1 : meta_data[7];
            state    <= SHIFT;
          end
        end
        LOAD: begin
          if (word_valid[bytesel]) begin
            shift    <= cur_byte;
            bits     <= 3'd0;
            byteDone <= 1'b0;
            tx       <= cs_s ? 1'b1 : cur_byte[7];
            state    <= SHIFT;
          end else begin
            state <= NEXT;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            // Deselect restarts the byte from its MSB.
            bits <= 3'd0;
            tx   <= 1'b1;
          end else if (shift_edge) begin
            bits <= bits_inc;
            if (bits == 3'd7) begin
              byteDone <= 1'b1;
              tx       <= 1'b1;
              state    <= NEXT;
            end else begin
              tx <= shift[~bits_inc];
            end
          end else begin
            tx <= shift[~bits];
          end
        end
        NEXT: begin
          if (bytesel == LAST) begin
            state <= IDLE;
          end else begin
            bytesel <= bytesel + 1'b1;
            state   <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_transmitter_wide.sv
// Self-checking bench for spi_transmitter_wide (default build, CPOL=1).
module tb_spi_transmitter_wide;

  logic        clock = 1'b0;
  logic        extReset_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs = 1'b1;
  logic        send = 1'b0;
  logic [31:0] send_data = '0;
  logic [3:0]  send_valid = '0;
  logic        writeMeta = 1'b0;
  logic [7:0]  meta_data = '0;
  logic        query_id = 1'b0;
  logic        query_dataIn = 1'b0;
  logic [31:0] dataIn = '0;
  logic        tx, busy, byteDone, full, overflow;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic bd_q = 1'b1;
  logic [7:0] exp_q [$];

  spi_transmitter_wide dut (
    .clock        (clock),
    .extReset_n   (extReset_n),
    .sclk         (sclk),
    .cs           (cs),
    .send         (send),
    .send_data    (send_data),
    .send_valid   (send_valid),
    .writeMeta    (writeMeta),
    .meta_data    (meta_data),
    .query_id     (query_id),
    .query_dataIn (query_dataIn),
    .dataIn       (dataIn),
    .tx           (tx),
    .busy         (busy),
    .byteDone     (byteDone),
    .full         (full),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (byteDone && !bd_q) rises++;
    bd_q = byteDone;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_word(input logic [31:0] d, input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i]) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endtask

  task automatic do_send(input logic [31:0] d, input logic [3:0] v);
    @(negedge clock);
    send = 1'b1; send_data = d; send_valid = v;
    @(negedge clock);
    send = 1'b0;
    model_word(d, v);
  endtask

  task automatic shift_bits(input logic [7:0] b, input int nbits, input string tag);
    for (int i = 7; i > 7 - nbits; i--) begin
      repeat (8) @(negedge clock);
      chk(tag, tx, b[i]);
      sclk = 1'b0;
      repeat (8) @(negedge clock);
      sclk = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    int start, nbytes;
    start = rises;
    nbytes = exp_q.size();
    while (exp_q.size() > 0) shift_bits(exp_q.pop_front(), 8, tag);
    repeat (8) @(negedge clock);
    chk({tag, "_donecnt"}, rises - start, nbytes);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_tx_idle"}, tx, 1'b1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rv;
    int          start;

    repeat (3) @(negedge clock);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bytedone", byteDone, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    extReset_n = 1'b1;
    repeat (2) @(negedge clock);
    cs = 1'b0;
    repeat (4) @(negedge clock);

    do_send(32'hA1B2C3D4, 4'hF);
    drain("word_a1");

    // First byte 44 has MSB 0, so the third edge after the push is visible.
    @(negedge clock);
    send = 1'b1; send_data = 32'h11223344; send_valid = 4'b0101;
    @(negedge clock);
    send = 1'b0;
    model_word(32'h11223344, 4'b0101);
    @(negedge clock);
    chk("lat_busy", busy, 1'b1);
    chk("lat_tx_before", tx, 1'b1);
    @(negedge clock);
    chk("lat_tx_first", tx, 1'b0);
    drain("mask_0101");

    @(negedge clock);
    query_id = 1'b1;
    @(negedge clock);
    query_id = 1'b0;
    model_word(32'h534c4131, 4'hF);
    drain("query_id");

    @(negedge clock);
    writeMeta = 1'b1; meta_data = 8'h5A;
    @(negedge clock);
    writeMeta = 1'b0;
    exp_q.push_back(8'h5A);
    drain("meta");

    dataIn = $urandom;
    @(negedge clock);
    query_dataIn = 1'b1;
    @(negedge clock);
    query_dataIn = 1'b0;
    model_word(dataIn, 4'hF);
    drain("query_datain");

    // send outranks query_id in the same cycle; only one word is queued.
    rd = $urandom;
    @(negedge clock);
    send = 1'b1; query_id = 1'b1; send_data = rd; send_valid = 4'hF;
    @(negedge clock);
    send = 1'b0; query_id = 1'b0;
    model_word(rd, 4'hF);
    drain("priority");

    start = rises;
    do_send(32'hDEADBEEF, 4'h0);
    repeat (12) @(negedge clock);
    chk("zero_mask_busy", busy, 1'b0);
    chk("zero_mask_tx", tx, 1'b1);
    chk("zero_mask_donecnt", rises - start, 0);

    @(negedge clock);
    writeMeta = 1'b1; meta_data = 8'hF0;
    @(negedge clock);
    writeMeta = 1'b0;
    shift_bits(8'hF0, 3, "cs_part");
    cs = 1'b1;
    repeat (4) @(negedge clock);
    chk("cs_high_tx", tx, 1'b1);
    chk("cs_high_busy", busy, 1'b1);
    cs = 1'b0;
    exp_q.push_back(8'hF0);
    drain("cs_restart");

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        rd = $urandom;
        rv = 4'($urandom_range(0, 15));
        do_send(rd, rv);
      end
      drain("random");
    end

    // A metadata byte holds the FSM so the FIFO alone absorbs the next pushes.
    @(negedge clock);
    writeMeta = 1'b1; meta_data = 8'hC3;
    @(negedge clock);
    writeMeta = 1'b0;
    exp_q.push_back(8'hC3);
    for (int k = 0; k < 5; k++) begin
      rd = $urandom;
      send = 1'b1; send_data = rd; send_valid = 4'hF;
      if (k < 4) model_word(rd, 4'hF);
      @(negedge clock);
      if (k == 2) chk("full_after3", full, 1'b0);
      if (k == 3) begin
        chk("full_after4", full, 1'b1);
        chk("ovf_after4", overflow, 1'b0);
      end
    end
    send = 1'b0;
    @(negedge clock);
    chk("ovf_after5", overflow, 1'b1);
    drain("overflow_drain");
    chk("ovf_sticky", overflow, 1'b1);
    chk("full_drained", full, 1'b0);

    do_send(32'h0F1E2D3C, 4'hF);
    do_send(32'h4B5A6978, 4'hF);
    shift_bits(8'h3C, 3, "pre_reset");
    @(posedge clock);
    #2;
    extReset_n = 1'b0;
    #1;
    chk("async_tx", tx, 1'b1);
    chk("async_busy", busy, 1'b0);
    chk("async_ovf", overflow, 1'b0);
    chk("async_full", full, 1'b0);
    chk("async_bytedone", byteDone, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clock);
    extReset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_tx", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_transmitter_wide.md
Name: spi_transmitter_wide

Overview:
Parametrised successor to the 32-bit SPI sample transmitter. It buffers up to FIFO_DEPTH sample words of WORD_BYTES bytes each and serialises the valid bytes, byte 0 first, MSB-first within each byte, to the SPI master (PIC) on the selected sclk edge. It also serves ID/dataIn queries and single metadata bytes. It sits between the sampler/controller and the SPI pins, replacing the fixed 4-byte, unbuffered transmitter.

Parameters:
WORD_BYTES, 4, bytes per sample word (1..8).
FIFO_DEPTH, 4, word buffer depth (power of 2, >=2).
CPOL, 1, 1: shift out on falling sclk edge (legacy). 0: shift out on rising edge.
ID_WORD, 32'h534c4131, word returned on query_id ("SLA1"), zero-extended/truncated to WORD_BYTES*8.

Ports:
clock  in  1  system clock
extReset_n  in  1  reset, asynchronous, active-low
sclk  in  1  SPI clock from master
cs  in  1  SPI chip select, active-low
send  in  1  push send_data/send_valid into FIFO
send_data  in  WORD_BYTES*8  sample word
send_valid  in  WORD_BYTES  per-byte valid mask; clear bits are skipped
writeMeta  in  1  load meta_data as a single byte
meta_data  in  8  metadata byte
query_id  in  1  enqueue ID_WORD, all bytes valid
query_dataIn  in  1  enqueue dataIn, all bytes valid
dataIn  in  WORD_BYTES*8  raw input word
tx  out  1  serial data (MISO)
busy  out  1  FIFO non-empty or byte in flight
byteDone  out  1  current byte fully shifted or none loaded
full  out  1  FIFO full
overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (async, extReset_n=0) gives: state IDLE, FIFO empty, tx=1, busy=0, byteDone=1, full=0, overflow=0, bit counter 0, shift register 8'hFF.
- Push priority, one push per cycle: send > query_id > query_dataIn. A push while full is dropped and sets overflow. overflow clears only on reset. full is registered and asserts the cycle after the FIFO_DEPTH-th push.
- Edge detect: sclk is registered once (dly_sclk). The shift edge is dly_sclk & !sclk when CPOL=1, and !dly_sclk & sclk when CPOL=0.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the word into the word register, set bytesel=0, go to LOAD. Else if writeMeta, load meta_data into the shift register, clear byteDone, go to SHIFT.
  - LOAD: if the byte at bytesel is valid, load it, clear byteDone, go to SHIFT. Else skip it with no sclk consumed and go to NEXT.
  - SHIFT: on each shift edge with cs=0, increment bits. When bits wraps 7->0, set byteDone and go to NEXT.
  - NEXT: if bytesel==WORD_BYTES-1, go to IDLE. Else increment bytesel and go to LOAD.
- cs=1 holds bits at 0. A byte is restarted, not corrupted, if cs deasserts mid-byte.
- tx output: tx = 1 when cs=1 or byteDone=1. Otherwise tx = shift[~bits] (registered, MSB first).
- busy = FIFO non-empty | state!=IDLE | !byteDone. busy is registered (one-cycle latency) and asserts the cycle after a push.
- Latency: push to first bit valid on tx is 3 clocks (push, IDLE pop, LOAD).
- A send_valid mask of all zeros drains the word with no bytes transmitted.
- writeMeta is ignored outside IDLE or when the FIFO is non-empty.
- Push and pop in the same cycle are both honoured; the FIFO count is unchanged.

Optional Feature:
SPI_TX_SYNC_EN. When defined, sclk and cs pass through a 2-flop synchroniser before edge detection, adding 2 clocks of edge latency; use for asynchronous master clocks. When undefined, the single-register legacy edge detect is used and sclk/cs must already be synchronous to clock.

Decomposition:
- Package spi_tx_pkg holds:
  - state typedef (IDLE, LOAD, SHIFT, NEXT)
  - SPI_TX_ID_DEFAULT constant
  - byte-index width function clog2(WORD_BYTES)
- Sub-module spi_tx_fifo (parametrised width/depth, synchronous FIFO with full/empty/count) holds {send_valid, send_data} entries.

Test Plan:
- Reset then send 32'hA1B2C3D4, valid=4'hF, CPOL=1, 32 falling sclk edges with cs=0 -> tx bytes D4,C3,B2,A1 MSB-first; byteDone pulses 4 times; busy drops after the last byte.
- send 32'h11223344, valid=4'b0101 -> only 44 and 22 transmitted; 16 edges suffice; busy then 0.
- 5 sends back-to-back, FIFO_DEPTH=4, no sclk -> full=1 after the 4th push; overflow=1 after the 5th; the first 4 words are transmitted intact afterwards.
- query_id in IDLE -> 31,41,4C,53 transmitted. writeMeta with meta_data=8'h5A, FIFO empty -> single byte 5A.
- cs deasserted after 3 bits of byte 8'hF0 -> bits reset; after cs reasserts, the full F0 is retransmitted; tx=1 while cs=1.
- extReset_n pulsed low mid-byte -> tx=1, busy=0, overflow=0, FIFO empty immediately, without waiting for a clock edge.
